// File: rtl/branch_unit_pkg.sv
// Shared definitions for the ID-stage branch controller: FSM encoding,
// 2-bit branch-history counter values and the saturating counter step.
package branch_unit_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } br_state_t;

    localparam logic [1:0] SNT       = 2'd0;
    localparam logic [1:0] WNT       = 2'd1;
    localparam logic [1:0] WT        = 2'd2;
    localparam logic [1:0] ST        = 2'd3;
    localparam logic [1:0] BHT_RESET = WNT;

    // One training step of a 2-bit saturating counter.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && cnt != ST) begin
            res = cnt + 2'd1;
        end else if (!up && cnt != SNT) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters, one
// combinational read port for IF prediction and one synchronous training
// write port. The read returns the pre-write value on an index collision.
module branch_bht
    import branch_unit_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt_reg  [DEPTH];
    logic [1:0] cnt_next [DEPTH];

    // Per-entry next value: only the addressed entry trains.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign cnt_next[gi] = (wr_en && wr_idx == IDX_W'(gi))
                                ? sat_step(cnt_reg[gi], wr_taken)
                                : cnt_reg[gi];
        end
    endgenerate

    // Table storage; every entry returns to weakly-not-taken on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                cnt_reg[i] <= BHT_RESET;
            end else begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign rd_cnt = cnt_reg[rd_idx];

endmodule

// File: rtl/branch_unit.sv
// ID-stage branch controller: stalls until both operands are forwarded,
// resolves beq/bne with a 32-bit equality compare, trains the BHT, raises
// a one-cycle redirect/flush on a mispredict and keeps saturating stats.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_bne,
    input  logic [31:0]      id_pc,
    input  logic             id_pred_taken,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      rd1,
    input  logic [31:0]      rd2,
    output logic             stall_id,
    output logic             pc_redirect,
    output logic             redirect_taken,
    output logic             flush_if,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    br_state_t        state_reg, state_next;
    logic [CNT_W-1:0] br_cnt_reg, miss_cnt_reg;

    logic       branch_in_id;
    logic       ops_ready;
    logic       resolve;
    logic       taken;
    logic       mispredict;
    logic [1:0] pred_cnt;

    assign branch_in_id = id_valid & id_is_branch;
    assign ops_ready    = rs_ready & rt_ready;
    // Reset cycle never resolves, so a branch caught in reset leaves no trace.
    assign resolve      = branch_in_id & ops_ready & ~reset;
    assign taken        = (rd1 == rd2) ^ id_bne;
    assign mispredict   = resolve & (taken != id_pred_taken);

    branch_bht #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_cnt   (pred_cnt),
        .wr_en    (resolve),
        .wr_idx   (id_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign pred_taken = pred_cnt[1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: wait while a branch lacks an operand; leave on resolve or
    // when the branch disappears from ID.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (branch_in_id && !ops_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!branch_in_id || ops_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control outputs: stall while waiting for operands, redirect only on
    // the resolving cycle (which by construction is never a stall cycle).
    always_comb begin
        stall_id       = 1'b0;
        pc_redirect    = 1'b0;
        redirect_taken = 1'b0;
        case (state_reg)
            S_IDLE, S_WAIT: begin
                stall_id       = branch_in_id & ~ops_ready & ~reset;
                pc_redirect    = mispredict;
                redirect_taken = mispredict & taken;
            end
            default: begin
                stall_id = 1'b0;
            end
        endcase
    end

    assign flush_if = pc_redirect;

    // Statistics counters, both saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_reg   <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (resolve && br_cnt_reg != '1) begin
                br_cnt_reg <= br_cnt_reg + 1'b1;
            end
            if (mispredict && miss_cnt_reg != '1) begin
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
        end
    end

    assign br_cnt   = br_cnt_reg;
    assign miss_cnt = miss_cnt_reg;

    // PC bits outside the table index and the counter LSB are not needed.
    logic unused_bits;
    assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                           id_pc[31:IDX_W+2], id_pc[1:0], pred_cnt[0]};

endmodule
